// File: rtl/qe_sampler_pkg.sv
// qe_sampler_pkg
//   Shared definitions for the quadrature-encoder sampler:
//   CPU register map (region codes and word offsets), CTRL/STATUS
//   bit positions and the sweep FSM state encoding.
package qe_sampler_pkg;

  // address[5:4] selects the region, address[3:0] the word within it
  localparam logic [1:0] REGION_CSR   = 2'b00;
  localparam logic [1:0] REGION_SNAP  = 2'b01;
  localparam logic [1:0] REGION_DELTA = 2'b10;

  localparam logic [3:0] WORD_CTRL      = 4'd0;
  localparam logic [3:0] WORD_PERIOD    = 4'd1;
  localparam logic [3:0] WORD_STATUS    = 4'd2;
  localparam logic [3:0] WORD_SWEEP_CNT = 4'd3;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_IE_BIT   = 1;
  localparam int unsigned CTRL_TRIG_BIT = 2;

  localparam int unsigned STATUS_DONE_BIT    = 0;
  localparam int unsigned STATUS_OVERRUN_BIT = 1;
  localparam int unsigned STATUS_BUSY_BIT    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/qe_tick_timer.sv
// qe_tick_timer
//   Sample-period down-counter. While disabled it tracks PERIOD; while
//   enabled it counts down and pulses tick for one cycle when it reaches 1,
//   reloading PERIOD at that point. A count of 0 (PERIOD=0) holds forever.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous reset, active-low
//   en     - CTRL.EN
//   period - PERIOD register
//   tick   - one-cycle sample tick
module qe_tick_timer
  import qe_sampler_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] period,
  output logic        tick
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    tick    = 1'b0;
    count_d = count_q;
    if (!en) begin
      count_d = period;
    end else if (count_q == 32'd1) begin
      tick    = 1'b1;
      count_d = period;
    end else if (count_q != '0) begin
      count_d = count_q - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/qe_sampler.sv
// qe_sampler
//   Periodic sweep scheduler and Avalon-MM master for the QUAD_ENCODER
//   count bank. Each sweep reads encoders 0..pENCODERS-1, latches a
//   snapshot per encoder and the signed delta against the previous sweep,
//   and raises DONE (and oIRQ when enabled) at the end.
// Ports:
//   iCLK, iRESET            - clock, asynchronous active-low reset
//   iAVL_*/oAVL_READ_DATA   - CPU slave (registered read data, latency 1)
//   oQE_ADDRESS, oQE_READ   - read request to QUAD_ENCODER
//   iQE_READ_DATA           - encoder count, valid pQE_READ_LATENCY later
//   oIRQ                    - STATUS.DONE & CTRL.IE
module qe_sampler
  import qe_sampler_pkg::*;
#(
  parameter int unsigned pENCODERS        = 5,
  parameter int unsigned pQE_READ_LATENCY = 1,
  parameter int unsigned pDEFAULT_PERIOD  = 50000
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic [5:0]  iAVL_ADDRESS,
  input  logic        iAVL_READ,
  output logic [31:0] oAVL_READ_DATA,
  input  logic        iAVL_WRITE,
  input  logic [31:0] iAVL_WRITE_DATA,
  output logic [3:0]  oQE_ADDRESS,
  output logic        oQE_READ,
  input  logic [31:0] iQE_READ_DATA,
  output logic        oIRQ
);

  localparam logic [3:0] LAST_IDX  = 4'(pENCODERS - 1);
  localparam logic [1:0] WAIT_LAST =
    (pQE_READ_LATENCY > 1) ? 2'(pQE_READ_LATENCY - 2) : 2'd0;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic [31:0] period_q, period_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;
  logic [31:0] sweep_cnt_q, sweep_cnt_d;
  logic        primed_q, primed_d;
  logic        clr_pend_q, clr_pend_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] snap_q  [pENCODERS];
  logic [31:0] snap_d  [pENCODERS];
  logic [31:0] delta_q [pENCODERS];
  logic [31:0] delta_d [pENCODERS];

  logic        tick;
  logic        wr_csr;
  logic [1:0]  region;
  logic [3:0]  word;
  logic        trig;
  logic        start_req;
  logic        en_fall;
  logic        busy;
  logic [31:0] rd_word;

  qe_tick_timer u_timer (
    .clk    (iCLK),
    .rst_n  (iRESET),
    .en     (en_q),
    .period (period_q),
    .tick   (tick)
  );

  assign region    = iAVL_ADDRESS[5:4];
  assign word      = iAVL_ADDRESS[3:0];
  assign wr_csr    = iAVL_WRITE && (region == REGION_CSR);
  assign trig      = wr_csr && (word == WORD_CTRL) && iAVL_WRITE_DATA[CTRL_TRIG_BIT];
  assign start_req = tick | trig;
  assign busy      = (state_q != ST_IDLE);

  // Control and status registers
  always_comb begin
    en_d     = en_q;
    ie_d     = ie_q;
    period_d = period_q;
    done_d   = done_q;
    ovr_d    = ovr_q;
    if (wr_csr && (word == WORD_CTRL)) begin
      en_d = iAVL_WRITE_DATA[CTRL_EN_BIT];
      ie_d = iAVL_WRITE_DATA[CTRL_IE_BIT];
    end
    if (wr_csr && (word == WORD_PERIOD)) begin
      period_d = iAVL_WRITE_DATA;
    end
    if (wr_csr && (word == WORD_STATUS)) begin
      if (iAVL_WRITE_DATA[STATUS_DONE_BIT])    done_d = 1'b0;
      if (iAVL_WRITE_DATA[STATUS_OVERRUN_BIT]) ovr_d  = 1'b0;
    end
    // hardware set is applied after the W1C so it wins a same-cycle clash
    if (start_req && busy)     ovr_d  = 1'b1;
    if (state_q == ST_DONE)    done_d = 1'b1;
  end

  assign en_fall = en_q & ~en_d;

  // Sweep FSM and snapshot/delta bank
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    snap_d      = snap_q;
    delta_d     = delta_q;
    sweep_cnt_d = sweep_cnt_q;
    primed_d    = primed_q;
    clr_pend_d  = clr_pend_q;

    // Disabling outside a sweep un-primes at once; during a sweep the
    // request is remembered and applied when that sweep finishes.
    if (en_fall) begin
      if (state_q == ST_IDLE) primed_d   = 1'b0;
      else                    clr_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          idx_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wcnt_d  = '0;
        state_d = (pQE_READ_LATENCY > 1) ? ST_WAIT : ST_CAPTURE;
      end
      ST_WAIT: begin
        if (wcnt_q == WAIT_LAST) state_d = ST_CAPTURE;
        else                     wcnt_d  = wcnt_q + 2'd1;
      end
      ST_CAPTURE: begin
        for (int unsigned i = 0; i < pENCODERS; i++) begin
          if (idx_q == 4'(i)) begin
            delta_d[i] = primed_q ? (iQE_READ_DATA - snap_q[i]) : '0;
            snap_d[i]  = iQE_READ_DATA;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: begin
        primed_d    = ~(clr_pend_q | en_fall);
        clr_pend_d  = 1'b0;
        sweep_cnt_d = sweep_cnt_q + 32'd1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // CPU read mux
  always_comb begin
    rd_word = '0;
    case (region)
      REGION_CSR: begin
        case (word)
          WORD_CTRL: begin
            rd_word[CTRL_EN_BIT] = en_q;
            rd_word[CTRL_IE_BIT] = ie_q;
          end
          WORD_PERIOD: rd_word = period_q;
          WORD_STATUS: begin
            rd_word[STATUS_DONE_BIT]    = done_q;
            rd_word[STATUS_OVERRUN_BIT] = ovr_q;
            rd_word[STATUS_BUSY_BIT]    = busy;
          end
          WORD_SWEEP_CNT: rd_word = sweep_cnt_q;
          default: rd_word = '0;
        endcase
      end
      REGION_SNAP: begin
        for (int unsigned i = 0; i < pENCODERS; i++) begin
          if (word == 4'(i)) rd_word = snap_q[i];
        end
      end
      REGION_DELTA: begin
        for (int unsigned i = 0; i < pENCODERS; i++) begin
          if (word == 4'(i)) rd_word = delta_q[i];
        end
      end
      default: rd_word = '0;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (iAVL_READ) rdata_d = rd_word;
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      wcnt_q      <= '0;
      en_q        <= 1'b0;
      ie_q        <= 1'b0;
      period_q    <= 32'(pDEFAULT_PERIOD);
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      sweep_cnt_q <= '0;
      primed_q    <= 1'b0;
      clr_pend_q  <= 1'b0;
      rdata_q     <= '0;
      for (int unsigned i = 0; i < pENCODERS; i++) begin
        snap_q[i]  <= '0;
        delta_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      en_q        <= en_d;
      ie_q        <= ie_d;
      period_q    <= period_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      sweep_cnt_q <= sweep_cnt_d;
      primed_q    <= primed_d;
      clr_pend_q  <= clr_pend_d;
      rdata_q     <= rdata_d;
      for (int unsigned i = 0; i < pENCODERS; i++) begin
        snap_q[i]  <= snap_d[i];
        delta_q[i] <= delta_d[i];
      end
    end
  end

  // Derived straight from the state register so reset drops it immediately
  assign oQE_READ       = (state_q == ST_ISSUE);
  assign oQE_ADDRESS    = idx_q;
  assign oIRQ           = done_q & ie_q;
  assign oAVL_READ_DATA = rdata_q;

endmodule

// File: tb/tb_qe_sampler.sv
module tb_qe_sampler;

  localparam int N     = 5;
  localparam int L     = 1;
  localparam int SWEEP = N * (L + 1) + 1;

  logic        iCLK = 1'b0;
  logic        iRESET = 1'b0;
  logic [5:0]  iAVL_ADDRESS = '0;
  logic        iAVL_READ = 1'b0;
  logic [31:0] oAVL_READ_DATA;
  logic        iAVL_WRITE = 1'b0;
  logic [31:0] iAVL_WRITE_DATA = '0;
  logic [3:0]  oQE_ADDRESS;
  logic        oQE_READ;
  logic [31:0] iQE_READ_DATA = '0;
  logic        oIRQ;

  int tests = 0;
  int fails = 0;

  logic [31:0] enc [N];

  always #5 iCLK = ~iCLK;

  qe_sampler #(
    .pENCODERS        (N),
    .pQE_READ_LATENCY (L),
    .pDEFAULT_PERIOD  (50000)
  ) dut (
    .iCLK            (iCLK),
    .iRESET          (iRESET),
    .iAVL_ADDRESS    (iAVL_ADDRESS),
    .iAVL_READ       (iAVL_READ),
    .oAVL_READ_DATA  (oAVL_READ_DATA),
    .iAVL_WRITE      (iAVL_WRITE),
    .iAVL_WRITE_DATA (iAVL_WRITE_DATA),
    .oQE_ADDRESS     (oQE_ADDRESS),
    .oQE_READ        (oQE_READ),
    .iQE_READ_DATA   (iQE_READ_DATA),
    .oIRQ            (oIRQ)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // QUAD_ENCODER slave: data valid L cycles after the request, junk otherwise
  always @(negedge iCLK) begin : qe_slave
    logic [3:0] a;
    if (iRESET && oQE_READ) begin
      a = oQE_ADDRESS;
      iQE_READ_DATA = 32'hBAD0_0000 | 32'(a);
      repeat (L) @(posedge iCLK);
      #1 iQE_READ_DATA = (a < N) ? enc[a] : 32'hDEAD_BEEF;
      @(posedge iCLK);
      #1 iQE_READ_DATA = 32'hBAD1_0000;
    end
  end

  // ---------------- behavioural model ----------------
  longint      cyc = 0;
  bit          m_en, m_ie, m_done, m_ovr, m_primed, m_pend, m_active;
  logic [31:0] m_period, m_cnt;
  logic [31:0] m_snap [N];
  logic [31:0] m_delta [N];
  longint      m_s, m_next_tick;
  bit          rd_pend;
  logic [31:0] rd_exp;

  function automatic void model_reset();
    m_en = 0; m_ie = 0; m_done = 0; m_ovr = 0; m_primed = 0; m_pend = 0;
    m_active = 0; m_period = 32'd50000; m_cnt = '0; m_s = 0; m_next_tick = -1;
    rd_pend = 0;
    for (int i = 0; i < N; i++) begin
      m_snap[i] = '0;
      m_delta[i] = '0;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] a, input bit busy);
    logic [31:0] r;
    int w;
    r = '0;
    w = int'(a[3:0]);
    case (a[5:4])
      2'b00: case (w)
        0: r = {30'b0, m_ie, m_en};
        1: r = m_period;
        2: r = {29'b0, busy, m_ovr, m_done};
        3: r = m_cnt;
        default: r = '0;
      endcase
      2'b01: if (w < N) r = m_snap[w];
      2'b10: if (w < N) r = m_delta[w];
      default: r = '0;
    endcase
    return r;
  endfunction

  // Sweep started at cycle s occupies cycles s+1..s+SWEEP; encoder i is
  // requested at s+1+i*(L+1) and captured L cycles later; the last one is DONE.
  always @(negedge iCLK) begin : compare
    bit busy, issue, tick, trig, new_en, fall;
    longint k;
    int i;
    cyc++;
    if (!iRESET) begin
      model_reset();
    end else begin
      if (rd_pend) check("avl_rdata", oAVL_READ_DATA, rd_exp);
      rd_pend = 0;
      busy  = m_active && cyc >= m_s + 1 && cyc <= m_s + SWEEP;
      k     = cyc - m_s - 1;
      issue = busy && (k % (L + 1)) == 0 && (k / (L + 1)) < N;
      check("qe_read", 32'(oQE_READ), 32'(issue));
      if (issue) check("qe_address", 32'(oQE_ADDRESS), 32'(k / (L + 1)));
      check("irq", 32'(oIRQ), 32'(m_done & m_ie));
      if (iAVL_READ) begin
        rd_pend = 1;
        rd_exp  = model_read(iAVL_ADDRESS, busy);
      end

      tick   = m_en && cyc == m_next_tick;
      trig   = iAVL_WRITE && iAVL_ADDRESS == 6'h00 && iAVL_WRITE_DATA[2];
      new_en = m_en;

      if (busy && (k % (L + 1)) == L && (k / (L + 1)) < N) begin
        i = int'(k / (L + 1));
        m_delta[i] = m_primed ? enc[i] - m_snap[i] : 32'd0;
        m_snap[i]  = enc[i];
      end

      if (iAVL_WRITE && iAVL_ADDRESS[5:4] == 2'b00) begin
        case (iAVL_ADDRESS[3:0])
          4'd0: begin new_en = iAVL_WRITE_DATA[0]; m_ie = iAVL_WRITE_DATA[1]; end
          4'd2: begin
            if (iAVL_WRITE_DATA[0]) m_done = 0;
            if (iAVL_WRITE_DATA[1]) m_ovr = 0;
          end
          default: ;
        endcase
      end

      fall = m_en && !new_en;
      if (fall) begin
        if (busy) m_pend = 1;
        else      m_primed = 0;
      end

      if (tick || trig) begin
        if (busy) m_ovr = 1;
        else begin
          m_s = cyc;
          m_active = 1;
        end
      end

      if (busy && cyc == m_s + SWEEP) begin
        m_primed = !m_pend;
        m_pend   = 0;
        m_cnt    = m_cnt + 32'd1;
        m_done   = 1;
      end

      if (tick || (!m_en && new_en))
        m_next_tick = (m_period == 0) ? -1 : cyc + longint'(m_period);
      m_en = new_en;
      if (iAVL_WRITE && iAVL_ADDRESS == 6'h01) m_period = iAVL_WRITE_DATA;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic avl_write(input logic [5:0] a, input logic [31:0] d);
    @(posedge iCLK); #1;
    iAVL_ADDRESS = a; iAVL_WRITE_DATA = d; iAVL_WRITE = 1'b1;
    @(posedge iCLK); #1;
    iAVL_WRITE = 1'b0;
  endtask

  task automatic avl_read(input logic [5:0] a, output logic [31:0] d);
    @(posedge iCLK); #1;
    iAVL_ADDRESS = a; iAVL_READ = 1'b1;
    @(posedge iCLK); #1;
    iAVL_READ = 1'b0;
    @(negedge iCLK);
    d = oAVL_READ_DATA;
  endtask

  task automatic read_expect(input string name, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    avl_read(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_irq(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge iCLK);
      if (oIRQ) break;
    end
    check(name, 32'(k < budget), 32'd1);
  endtask

  // TRIG with EN=0: one 11-cycle sweep, addresses 0..4, DONE two cycles later
  task automatic trig_sweep(input string name);
    logic [3:0] addrs [$];
    int k;
    avl_write(6'h02, 32'h3);
    @(posedge iCLK); #1;
    iAVL_ADDRESS = 6'h00; iAVL_WRITE_DATA = 32'h6; iAVL_WRITE = 1'b1;
    @(posedge iCLK); #1;
    iAVL_WRITE = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(negedge iCLK);
      if (oQE_READ) addrs.push_back(oQE_ADDRESS);
      if (oIRQ) break;
    end
    check({name, "_irq_cycle"}, 32'(k), 32'd12);
    check({name, "_pulses"}, 32'(addrs.size()), 32'd5);
    foreach (addrs[j]) check({name, "_addr_seq"}, 32'(addrs[j]), 32'(j));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin : main
    int n;
    for (int i = 0; i < N; i++) enc[i] = '0;
    repeat (3) @(posedge iCLK);
    #1 iRESET = 1'b1;

    // reset state
    @(negedge iCLK);
    check("reset_irq", 32'(oIRQ), 32'd0);
    check("reset_qe_read", 32'(oQE_READ), 32'd0);
    read_expect("reset_ctrl",   6'h00, 32'd0);
    read_expect("reset_period", 6'h01, 32'd50000);
    read_expect("reset_status", 6'h02, 32'd0);
    read_expect("reset_snap0",  6'h10, 32'd0);

    // periodic sweeps
    for (int i = 0; i < N; i++) enc[i] = 32'(100 + i);
    avl_write(6'h01, 32'd40);
    avl_write(6'h00, 32'h3);
    wait_irq("sweep1_done", 120);
    read_expect("sweep1_snap0",  6'h10, 32'd100);
    read_expect("sweep1_snap4",  6'h14, 32'd104);
    read_expect("sweep1_delta1", 6'h21, 32'd0);
    avl_write(6'h02, 32'h1);
    for (int i = 0; i < N; i++) enc[i] = (i % 2 == 0) ? enc[i] + 32'd7 : enc[i] - 32'd3;
    wait_irq("sweep2_done", 120);
    avl_write(6'h00, 32'h2);
    read_expect("sweep2_delta0", 6'h20, 32'd7);
    read_expect("sweep2_delta1", 6'h21, 32'hFFFF_FFFD);
    read_expect("sweep2_delta4", 6'h24, 32'd7);
    read_expect("sweep2_cnt",    6'h03, 32'd2);

    // overrun: 8-cycle period against an 11-cycle sweep
    avl_write(6'h02, 32'h3);
    avl_write(6'h01, 32'd8);
    avl_write(6'h00, 32'h3);
    repeat (30) @(posedge iCLK);
    avl_write(6'h00, 32'h2);
    repeat (20) @(posedge iCLK);
    read_expect("overrun_status", 6'h02, 32'h3);
    avl_write(6'h02, 32'h2);
    read_expect("overrun_cleared", 6'h02, 32'h1);

    // counter wrap through TRIG sweeps; first one is unprimed after EN fell
    enc[2] = 32'hFFFF_FFFE;
    enc[3] = 32'h0000_0003;
    trig_sweep("trig1");
    read_expect("unprimed_delta2", 6'h22, 32'd0);
    enc[2] = 32'h0000_0003;
    enc[3] = 32'hFFFF_FFFE;
    trig_sweep("trig2");
    read_expect("wrap_delta2_pos", 6'h22, 32'd5);
    read_expect("wrap_delta3_neg", 6'h23, 32'hFFFF_FFFB);
    read_expect("sweep_cnt_6",     6'h03, 32'd6);
    read_expect("unmapped_csr",    6'h05, 32'd0);
    read_expect("snap_oob",        6'h15, 32'd0);
    read_expect("region3",         6'h30, 32'd0);

    // reset in the third ISSUE cycle
    avl_write(6'h02, 32'h3);
    @(posedge iCLK); #1;
    iAVL_ADDRESS = 6'h00; iAVL_WRITE_DATA = 32'h6; iAVL_WRITE = 1'b1;
    @(posedge iCLK); #1;
    iAVL_WRITE = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && n < 3; k++) begin
      @(negedge iCLK);
      if (oQE_READ) n++;
    end
    check("third_issue_seen", 32'(n), 32'd3);
    #2 iRESET = 1'b0;
    #1;
    check("async_qe_read_drop", 32'(oQE_READ), 32'd0);
    check("async_irq_drop", 32'(oIRQ), 32'd0);
    repeat (2) @(posedge iCLK);
    #1 iRESET = 1'b1;
    repeat (30) @(posedge iCLK);
    read_expect("post_reset_ctrl",   6'h00, 32'd0);
    read_expect("post_reset_period", 6'h01, 32'd50000);
    read_expect("post_reset_status", 6'h02, 32'd0);
    read_expect("post_reset_cnt",    6'h03, 32'd0);
    read_expect("post_reset_snap0",  6'h10, 32'd0);
    read_expect("post_reset_delta1", 6'h21, 32'd0);

    repeat (2) @(posedge iCLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/qe_sampler.md
Name: qe_sampler

Overview:
- Periodic scheduler and Avalon-MM master for the QUAD_ENCODER count bank.
- Every sample period it sweeps encoders 0..pENCODERS-1 in order and reads each 32-bit count.
- For each encoder it latches a snapshot and computes the signed delta (velocity) against the previous sweep.
- Snapshots and deltas are exposed to the CPU through its own Avalon slave. A sweep-done interrupt lets software read coherent velocity data without polling the encoder block.

Parameters:
- pENCODERS, 5, number of encoders swept (1..16).
- pQE_READ_LATENCY, 1, fixed read latency of the QUAD_ENCODER slave, in cycles (1..3).
- pDEFAULT_PERIOD, 50000, reset value of the PERIOD register, in clocks.

Ports:
- iCLK  in  1  system clock.
- iRESET  in  1  asynchronous reset, active-low.
- iAVL_ADDRESS  in  6  CPU slave word address.
- iAVL_READ  in  1  CPU slave read strobe.
- oAVL_READ_DATA  out  32  CPU read data, valid 1 cycle after iAVL_READ.
- iAVL_WRITE  in  1  CPU slave write strobe.
- iAVL_WRITE_DATA  in  32  CPU write data.
- oQE_ADDRESS  out  4  encoder index presented to QUAD_ENCODER iAVL_ADDRESS.
- oQE_READ  out  1  read strobe to QUAD_ENCODER.
- iQE_READ_DATA  in  32  count returned by QUAD_ENCODER.
- oIRQ  out  1  level interrupt, equal to STATUS.DONE & CTRL.IE.

Behaviour:
- Reset: all outputs are 0. CTRL=0, PERIOD=pDEFAULT_PERIOD, STATUS=0, SWEEP_CNT=0, all snapshots and deltas are 0, PRIMED=0, FSM is IDLE.
- CPU register map, selected by address[5:4]:
  - 00: word 0 is CTRL (bit0 EN, bit1 IE, bit2 TRIG write-1-pulse, reads 0).
  - 00: word 1 is PERIOD.
  - 00: word 2 is STATUS (bit0 DONE, bit1 OVERRUN, bit2 BUSY; bits 0 and 1 are write-1-to-clear).
  - 00: word 3 is SWEEP_CNT (read-only, wraps at 2^32).
  - 01: word i is SNAP[i].
  - 10: word i is DELTA[i].
  - Unmapped words and i>=pENCODERS read 0; writes to them are ignored.
- Read data is registered: latency 1, no waitrequest.
- Tick timer:
  - Down-counter loaded from PERIOD while EN=0.
  - While EN=1 it decrements each cycle. At 1 it emits a one-cycle tick and reloads from PERIOD.
  - A PERIOD write takes effect at the next reload.
  - PERIOD=0 produces no ticks; the timer holds.
- Sweep start: a tick, or TRIG written while FSM is IDLE.
  - If a tick or TRIG arrives while the FSM is not IDLE, it is dropped and OVERRUN is set.
  - Tick and TRIG in the same cycle give one sweep.
- FSM:
  - IDLE: on start, idx<=0, go to ISSUE.
  - ISSUE: oQE_READ=1 and oQE_ADDRESS=idx for exactly one cycle, then go to WAIT.
  - WAIT: hold pQE_READ_LATENCY-1 cycles, then go to CAPTURE. The data sample cycle is exactly pQE_READ_LATENCY cycles after the ISSUE cycle.
  - CAPTURE: DELTA[idx] <= PRIMED ? iQE_READ_DATA - SNAP[idx] (mod 2^32, two's-complement signed) : 0. SNAP[idx] <= iQE_READ_DATA.
    - If idx=pENCODERS-1, go to DONE; otherwise idx++ and go to ISSUE.
  - DONE: PRIMED<=1, SWEEP_CNT++, STATUS.DONE<=1, go to IDLE.
- Sweep length is pENCODERS*(pQE_READ_LATENCY+1)+1 cycles from start to DONE.
- BUSY = FSM not IDLE.
- Counter wrap: the delta is taken modulo 2^32. 0xFFFFFFFE -> 0x00000003 gives +5; 0x00000003 -> 0xFFFFFFFE gives -5 (0xFFFFFFFB).
- Clearing EN mid-sweep: the current sweep completes; no further ticks occur. EN 1->0 also clears PRIMED after the current sweep, so the first sweep after re-enable reports deltas of 0.
- Simultaneous DONE set by hardware and W1C by CPU in the same cycle: set wins.
- Asserting iRESET mid-sweep aborts immediately to reset values. oQE_READ deasserts asynchronously.
- CPU reads during a sweep return the values committed so far. Per-word updates are atomic. Whole-bank coherence is guaranteed only once DONE is set.

Decomposition:
- Package qe_sampler_pkg holds:
  - register word-offset constants and region codes (CTRL, PERIOD, STATUS, SWEEP_CNT, SNAP, DELTA);
  - STATUS/CTRL bit positions;
  - the FSM state enum (IDLE, ISSUE, WAIT, CAPTURE, DONE).
- Sub-module qe_tick_timer contains the period down-counter, reload and tick generation, with inputs EN, PERIOD and output tick.

Test Plan:
- Reset then read: CTRL=0, PERIOD=50000, STATUS=0, SNAP0=0, oIRQ=0, oQE_READ=0.
- Encoder model returns 100+i. Write PERIOD=40, CTRL=0x3.
  - First sweep: SNAP[i]=100+i, DELTA=0, DONE=1, oIRQ=1.
  - Model counts advance by +7 and -3 alternately per encoder.
  - Second sweep: DELTA = 7 / 0xFFFFFFFD alternately; SWEEP_CNT=2.
- Wrap: encoder 2 goes 0xFFFFFFFE -> 0x00000003 across sweeps -> DELTA[2]=5.
- PERIOD=8 with pENCODERS=5 and latency 1 (sweep takes 11 cycles) -> OVERRUN=1 after the second tick. Write 0x2 to STATUS -> OVERRUN=0.
- With EN=0, write CTRL=0x4 (TRIG) -> exactly one sweep, 11 cycles; oQE_ADDRESS sequence 0,1,2,3,4; one oQE_READ pulse per index.
- Drop iRESET during the third ISSUE -> all registers return to reset values and oQE_READ=0 immediately. After release, no sweep occurs until EN is set.
